crc_div_p: RTL and testbench
============================

CRC_DIV_P -- requirements
Module: crc_div_p

Interface
REQ-001 Parameter N, default 64, frame length in bits.
REQ-002 Parameter DEG, default 9, generator degree; legal range 2..32.
REQ-003 Parameter POLY, default 9'h011, DEG-bit low-order tap mask of G(x) with implicit x^DEG (default G = x^9+x^4+1).
REQ-004 Parameter STEP, default 1, bits consumed per cycle; legal values 1..8; N mod STEP SHALL be 0.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request to begin a frame; sampled only in IDLE.
REQ-008 abort  input  1  cancels the frame in progress.
REQ-009 data_in  input  N  frame data, MSB (bit N-1) processed first.
REQ-010 busy  output  1  high in RUN state.
REQ-011 done  output  1  one-cycle pulse when the remainder is final.
REQ-012 count  output  $clog2(N+1)  number of frame bits consumed so far.
REQ-013 rem  output  DEG  remainder M(x) mod G(x), not augmented.
REQ-014 syn_ok  output  1  remainder-is-zero flag (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE, with no other reachable state.
REQ-016 IDLE with start=1 and abort=0: capture data_in into an internal shadow register, clear rem and count, and go to RUN.
REQ-017 After capture, data_in changes SHALL NOT affect the frame.
REQ-018 RUN, per edge: apply STEP serial iterations r = {r[DEG-2:0], b} ^ (r[DEG-1] ? POLY : 0), b taken from the shadow MSB-first, then count += STEP.
REQ-019 RUN: when count reaches N on an edge, go to DONE on that same edge; RUN SHALL last exactly N/STEP cycles.
REQ-020 DONE SHALL last one cycle with done=1 and SHALL then go to IDLE.
REQ-021 rem and count SHALL hold their final values in IDLE until the next accepted start.
REQ-022 start in RUN or DONE SHALL be ignored; it is not queued.
REQ-023 abort=1 in RUN or DONE: go to IDLE next edge, clear rem and count to 0, and generate no done pulse.
REQ-024 abort and start both high in IDLE: abort wins and no frame starts.
REQ-025 Remainder arithmetic SHALL be GF(2) only; count SHALL never exceed N.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, shadow=0, rem=0, count=0, busy=0, done=0, syn_ok=0.
REQ-027 rst asserted mid-RUN SHALL discard the frame, and no done SHALL follow release.
REQ-028 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro CRC_DIV_P_SYNDROME_EN defined: syn_ok SHALL be registered and equal (rem==0) while in DONE and IDLE after a completed frame; 0 in RUN, after abort and after reset.
REQ-030 Macro CRC_DIV_P_SYNDROME_EN undefined: syn_ok SHALL be tied to 0 and the zero-detect logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification (N=64, DEG=9, POLY=9'h011 unless stated)
REQ-031 STEP=1, data_in=64'h1FF, start pulse -> busy for 64 cycles, done high 64 cycles after the start edge, rem=9'h1FF, count=64.
REQ-032 STEP=1, data_in=64'h200 -> rem=9'h011; data_in=64'h211 -> rem=9'h000, and syn_ok=1 with CRC_DIV_P_SYNDROME_EN defined, 0 without it.
REQ-033 STEP=4 with the same three frames -> identical rem values, done 16 cycles after the start edge.
REQ-034 abort at count=20 -> next cycle IDLE, rem=0, count=0, no done; a following start with 64'h200 -> rem=9'h011.
REQ-035 start re-pulsed at count=10, and data_in changed mid-frame -> both ignored; result matches the originally captured frame.
REQ-036 rst asserted at count=30 -> outputs 0 immediately, no done after release; start on the first edge after release accepted.

Source files
------------

// File: rtl/crc_div_p.sv
// ---------------------------------------------------------------------------
// crc_div_p
//
// Purpose:
//   Polynomial divider over GF(2). A frame of N bits is captured on start and
//   shifted MSB-first, STEP bits per clock, through a DEG-bit long-division
//   register. The result is M(x) mod G(x), where G(x) = x^DEG + POLY. The
//   message is not augmented with DEG zero bits.
//
// Parameters:
//   N     frame length in bits (N mod STEP must be 0)
//   DEG   generator degree, 2..32
//   POLY  low-order tap mask of G(x); x^DEG is implicit
//   STEP  bits consumed per clock, 1..8
//
// Ports:
//   clk      sole clock, rising edge
//   rst      asynchronous, active-high reset
//   start    begin a frame; only looked at in IDLE
//   abort    cancel the frame in progress; also blocks a start in IDLE
//   data_in  frame data, bit N-1 processed first
//   busy     high while in RUN
//   done     one-cycle pulse in DONE, when rem is final
//   count    frame bits consumed so far
//   rem      remainder register
//   syn_ok   remainder-is-zero flag
//
// Configuration:
//   CRC_DIV_P_SYNDROME_EN  defined: syn_ok is a registered (rem == 0) flag for
//                          a completed frame. Undefined: syn_ok is tied to 0
//                          and no zero-detect logic is built.
// ---------------------------------------------------------------------------
module crc_div_p #(
    parameter int unsigned N              = 64,
    parameter int unsigned DEG            = 9,
    parameter logic [DEG-1:0] POLY        = 9'h011,
    parameter int unsigned STEP           = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [N-1:0]              data_in,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(N+1)-1:0]    count,
    output logic [DEG-1:0]            rem,
    output logic                      syn_ok
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    state_t           state;
    logic [N-1:0]     shadow;
    logic [DEG-1:0]   rem_nxt;
    logic [CW-1:0]    count_nxt;
    logic             last_step;

    // STEP serial long-division iterations. bits[STEP-1] is the oldest bit.
    function automatic logic [DEG-1:0] div_steps(input logic [DEG-1:0] r_in,
                                                 input logic [STEP-1:0] bits);
        logic [DEG-1:0] r;
        logic           fb;
        r = r_in;
        for (int i = STEP - 1; i >= 0; i--) begin
            fb = r[DEG-1];
            r  = {r[DEG-2:0], bits[i]};
            if (fb) begin
                r = r ^ POLY;
            end
        end
        return r;
    endfunction

    always_comb begin
        rem_nxt   = div_steps(rem, shadow[N-1 -: STEP]);
        count_nxt = count + CW'(STEP);
        last_step = (count_nxt == CW'(N));
    end

    // Control FSM with registered outputs. rem and count deliberately hold
    // their final value through DONE and IDLE until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            shadow <= '0;
            rem    <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start && !abort) begin
                        shadow <= data_in;
                        rem    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    if (abort) begin
                        rem   <= '0;
                        count <= '0;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        shadow <= shadow << STEP;
                        rem    <= rem_nxt;
                        count  <= count_nxt;
                        if (last_step) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (abort) begin
                        rem   <= '0;
                        count <= '0;
                    end
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef CRC_DIV_P_SYNDROME_EN
    // Flag is loaded with the final remainder on the edge into DONE, so it is
    // valid in the same cycle as done and then held in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syn_ok <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start && !abort) begin
                        syn_ok <= 1'b0;
                    end
                end
                StRun: begin
                    if (abort) begin
                        syn_ok <= 1'b0;
                    end else if (last_step) begin
                        syn_ok <= (rem_nxt == '0);
                    end
                end
                StDone: begin
                    if (abort) begin
                        syn_ok <= 1'b0;
                    end
                end
                default: begin
                    syn_ok <= 1'b0;
                end
            endcase
        end
    end
`else
    assign syn_ok = 1'b0;
`endif

endmodule

// File: tb/tb_crc_div_p.sv
// ---------------------------------------------------------------------------
// tb_crc_div_p
//
// Drives a STEP=1 and a STEP=4 instance of crc_div_p (N=64, DEG=9,
// G = x^9+x^4+1) from shared inputs. A vector table covers the main
// division function; hand-written sequences cover abort, start re-pulse,
// mid-frame data changes and reset.
// ---------------------------------------------------------------------------
module tb_crc_div_p;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [63:0] data_in;

    logic        busy1, done1, syn1;
    logic [6:0]  count1;
    logic [8:0]  rem1;
    logic        busy4, done4, syn4;
    logic [6:0]  count4;
    logic [8:0]  rem4;

    int checks = 0;
    int errors = 0;

`ifdef CRC_DIV_P_SYNDROME_EN
    localparam bit SynEn = 1'b1;
`else
    localparam bit SynEn = 1'b0;
`endif

    crc_div_p #(.N(64), .DEG(9), .POLY(9'h011), .STEP(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .data_in (data_in),
        .busy    (busy1),
        .done    (done1),
        .count   (count1),
        .rem     (rem1),
        .syn_ok  (syn1)
    );

    crc_div_p #(.N(64), .DEG(9), .POLY(9'h011), .STEP(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .data_in (data_in),
        .busy    (busy4),
        .done    (done4),
        .count   (count4),
        .rem     (rem4),
        .syn_ok  (syn4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a frame on both instances and check latency, result and hold.
    task automatic run_frame(input logic [63:0] d, input logic [8:0] er, input string nm);
        bit got1;
        bit got4;
        logic exp_syn;
        exp_syn = SynEn && (er == 9'h000);
        got1 = 1'b0;
        got4 = 1'b0;
        data_in = d;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, "_busy1_start"}, busy1, 1);
        chk({nm, "_busy4_start"}, busy4, 1);
        chk({nm, "_count1_start"}, count1, 0);
        chk({nm, "_syn1_run"}, syn1, 0);
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (!got4 && done4) begin
                got4 = 1'b1;
                chk({nm, "_lat4"}, i, 16);
                chk({nm, "_rem4"}, rem4, er);
                chk({nm, "_count4"}, count4, 64);
                chk({nm, "_syn4"}, syn4, exp_syn);
            end
            if (!got1 && done1) begin
                got1 = 1'b1;
                chk({nm, "_lat1"}, i, 64);
                chk({nm, "_rem1"}, rem1, er);
                chk({nm, "_count1"}, count1, 64);
                chk({nm, "_syn1"}, syn1, exp_syn);
                chk({nm, "_busy1_done"}, busy1, 0);
            end
            if (got1 && got4) break;
        end
        chk({nm, "_done1_seen"}, got1, 1);
        chk({nm, "_done4_seen"}, got4, 1);
        tick();
        chk({nm, "_done1_pulse"}, done1, 0);
        chk({nm, "_rem1_hold"}, rem1, er);
        chk({nm, "_count1_hold"}, count1, 64);
        chk({nm, "_syn1_hold"}, syn1, exp_syn);
    endtask

    typedef struct {
        logic [63:0] data;
        logic [8:0]  rem;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit seen;

        vecs[0] = '{data: 64'h1FF, rem: 9'h1FF};
        vecs[1] = '{data: 64'h200, rem: 9'h011};
        vecs[2] = '{data: 64'h211, rem: 9'h000};
        vecs[3] = '{data: 64'h000, rem: 9'h000};
        vecs[4] = '{data: 64'h100, rem: 9'h100};
        vecs[5] = '{data: 64'h400, rem: 9'h022};
        vecs[6] = '{data: 64'h800, rem: 9'h044};

        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        data_in = 64'h0;
        #12;
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0);
        chk("rst_count1", count1, 0);
        chk("rst_rem1", rem1, 0);
        chk("rst_syn1", syn1, 0);
        chk("rst_rem4", rem4, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].data, vecs[v].rem, $sformatf("vec%0d", v));
        end

        // abort and start together in IDLE: no frame, result held
        start = 1'b1;
        abort = 1'b1;
        data_in = 64'h1FF;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abst_busy1", busy1, 0);
        chk("abst_rem1", rem1, 9'h044);
        tick();
        chk("abst_busy1_late", busy1, 0);

        // abort at count 20
        data_in = 64'h1FF;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("abort_pre_count1", count1, 20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy1", busy1, 0);
        chk("abort_rem1", rem1, 0);
        chk("abort_count1", count1, 0);
        chk("abort_done1", done1, 0);
        chk("abort_syn1", syn1, 0);
        seen = 1'b0;
        repeat (70) begin
            tick();
            if (done1 || busy1) seen = 1'b1;
        end
        chk("abort_no_done1", seen, 0);
        run_frame(64'h200, 9'h011, "after_abort");

        // start re-pulse and data change mid-frame are ignored
        data_in = 64'h200;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        data_in = 64'h1FF;
        repeat (10) tick();
        chk("repulse_count1", count1, 10);
        start   = 1'b1;
        data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (done1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("repulse_done1_seen", seen, 1);
        chk("repulse_rem1", rem1, 9'h011);
        chk("repulse_count1", count1, 64);
        chk("repulse_rem4", rem4, 9'h011);
        tick();
        chk("repulse_idle1", busy1, 0);

        // reset at count 30
        data_in = 64'h1FF;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        chk("rst_mid_pre_count1", count1, 30);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy1", busy1, 0);
        chk("rst_mid_count1", count1, 0);
        chk("rst_mid_rem1", rem1, 0);
        chk("rst_mid_done1", done1, 0);
        chk("rst_mid_syn1", syn1, 0);
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        repeat (70) begin
            tick();
            if (done1 || done4 || busy1 || busy4) seen = 1'b1;
        end
        chk("rst_mid_no_done", seen, 0);

        // start on the very first edge after release
        rst = 1'b1;
        #2;
        rst = 1'b0;
        run_frame(64'h400, 9'h022, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
